sum_accum: RTL

- Downstream consumer of the 8+8-bit adder stage. It takes the adder's 9-bit sum stream over a busy/vld handshake.
- Sums each group of COUNT consecutive samples into one frame total.
- Emits each frame total over a second busy/vld interface through a 2-entry output buffer, so a stalled sink does not immediately stall the adder.

---
 rtl/sum_accum_pkg.sv | 17 +
 rtl/sum_accum_fifo2.sv | 45 ++++
 rtl/sum_accum.sv | 95 +++++++++
 3 files changed

// File: rtl/sum_accum_pkg.sv
// Shared defaults, width derivation and data typedefs for the frame accumulator.
package sum_accum_pkg;

  localparam int IN_W_DEF  = 9;
  localparam int COUNT_DEF = 4;

  // Frame-total width: enough headroom that COUNT full-scale samples never overflow.
  function automatic int calc_out_w(input int in_w, input int count);
    return in_w + $clog2(count);
  endfunction

  localparam int OUT_W_DEF = calc_out_w(IN_W_DEF, COUNT_DEF);

  typedef logic [IN_W_DEF-1:0]  sum_t;
  typedef logic [OUT_W_DEF-1:0] total_t;

endpackage

// File: rtl/sum_accum_fifo2.sv
// Two-entry FIFO with 1-bit pointers and a separate occupancy count,
// so full and empty are never ambiguous. Head reads as 0 when empty.
module sum_accum_fifo2 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occupancy
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   occ;

  // Pointer and occupancy bookkeeping; push/pop legality is guaranteed by the caller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage holds data only and needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign occupancy = occ;
  assign head      = (occ != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sum_accum.sv
// Frame accumulator: sums COUNT consecutive adder outputs into one total and
// hands totals to the sink through a 2-entry buffer, counting emitted frames.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int COUNT = COUNT_DEF,
  parameter int OUT_W = calc_out_w(IN_W, COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             din_busy,
  input  logic             din_vld,
  input  logic [IN_W-1:0]  din_data,
  input  logic             dout_busy,
  output logic             dout_vld,
  output logic [OUT_W-1:0] dout_data,
  output logic [7:0]       frame_cnt
);

  localparam int CNT_W = $clog2(COUNT);
  // The FSM state is the sample index: ACCUM below this value, LAST at it.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] din_ext;
  logic [OUT_W-1:0] sum_next;
  logic             is_last;
  logic             in_xfer;
  logic             out_xfer;
  logic             push;
  logic [1:0]       occupancy;
  logic [OUT_W-1:0] head;

  assign is_last  = (cnt == LAST_CNT);
  // Only the final sample of a frame can stall, and only on a full buffer.
  assign din_busy = is_last && (occupancy == 2'd2);
  assign in_xfer  = din_vld && !din_busy;
  assign din_ext  = OUT_W'(din_data);
  assign sum_next = acc + din_ext;
  // clr overrides frame completion, so a clearing transfer never pushes.
  assign push     = in_xfer && is_last && !clr;

  assign dout_vld  = (occupancy != 2'd0);
  assign dout_data = head;
  assign out_xfer  = dout_vld && !dout_busy;

  // Accumulator FSM: add in ACCUM, hand off and restart in LAST, restart on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      if (in_xfer) begin
        acc <= din_ext;
        cnt <= CNT_W'(1);
      end else begin
        acc <= '0;
        cnt <= '0;
      end
    end else if (in_xfer) begin
      if (is_last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_next;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Emitted-frame counter, wraps modulo 256.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 8'd0;
    end else if (out_xfer) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  sum_accum_fifo2 #(
    .W(OUT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sum_next),
    .pop       (out_xfer),
    .head      (head),
    .occupancy (occupancy)
  );

endmodule
